// File: rtl/branch_station_pkg.sv
// Shared constants and op decoding for the branch reservation station.
// Op codes are {funct3, opcode[6:0]} exactly as dispatched by decode.
package branch_station_pkg;

  localparam int TAG_W_DEF = 5;

  localparam logic [9:0] OP_JAL  = {3'b000, 7'b1101111};
  localparam logic [9:0] OP_JALR = {3'b000, 7'b1100111};
  localparam logic [9:0] OP_BEQ  = {3'b000, 7'b1100011};
  localparam logic [9:0] OP_BNE  = {3'b001, 7'b1100011};
  localparam logic [9:0] OP_BLT  = {3'b100, 7'b1100011};
  localparam logic [9:0] OP_BGE  = {3'b101, 7'b1100011};
  localparam logic [9:0] OP_BLTU = {3'b110, 7'b1100011};
  localparam logic [9:0] OP_BGEU = {3'b111, 7'b1100011};

  typedef enum logic [3:0] {
    K_BAD, K_JAL, K_JALR, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU
  } op_kind_e;

  // Anything that is not a recognised control-flow op decodes to K_BAD.
  function automatic op_kind_e decode_op(input logic [9:0] op);
    op_kind_e kind;
    case (op)
      OP_JAL:  kind = K_JAL;
      OP_JALR: kind = K_JALR;
      OP_BEQ:  kind = K_BEQ;
      OP_BNE:  kind = K_BNE;
      OP_BLT:  kind = K_BLT;
      OP_BGE:  kind = K_BGE;
      OP_BLTU: kind = K_BLTU;
      OP_BGEU: kind = K_BGEU;
      default: kind = K_BAD;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_station_resolve.sv
// Purely combinational branch resolution: direction, next PC, link value
// and misprediction for one entry whose operands are both available.
module branch_resolve
  import branch_station_pkg::*;
(
  input  logic [9:0]  op,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  input  logic        pred_taken,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] value,
  output logic        mispredict
);

  op_kind_e    kind;
  logic [31:0] pc_next;
  logic [31:0] pc_rel;
  logic        cond;

  assign kind    = decode_op(op);
  assign pc_next = pc + 32'd4;
  assign pc_rel  = pc + imm;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    cond       = 1'b0;
    taken      = 1'b0;
    target     = pc_next;
    value      = pc_next;
    mispredict = pred_taken;
    case (kind)
      K_BEQ:   cond = (vj == vk);
      K_BNE:   cond = (vj != vk);
      K_BLT:   cond = ($signed(vj) <  $signed(vk));
      K_BGE:   cond = ($signed(vj) >= $signed(vk));
      K_BLTU:  cond = (vj <  vk);
      K_BGEU:  cond = (vj >= vk);
      default: cond = 1'b0;
    endcase
    case (kind)
      K_JAL: begin
        taken      = 1'b1;
        target     = pc_rel;
        mispredict = !pred_taken;
      end
      K_JALR: begin
        taken      = 1'b1;
        target     = (vj + imm) & ~32'd1;
        mispredict = 1'b1;
      end
      K_BAD: begin
        // Unknown ops fall through as a not-taken jump so the ROB can retire them.
        taken = 1'b0;
      end
      default: begin
        taken      = cond;
        target     = cond ? pc_rel : pc_next;
        value      = 32'd0;
        mispredict = cond ^ pred_taken;
      end
    endcase
  end

endmodule

// File: rtl/branch_station.sv
// Branch reservation station: free-slot allocation, CDB snooping with
// insert-time bypass, oldest-first issue through an age matrix, flush.
module branch_station
  import branch_station_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEF,
  parameter int CDB_N = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [9:0]                 in_op,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_imm,
  input  logic [TAG_W-1:0]           in_qj,
  input  logic [TAG_W-1:0]           in_qk,
  input  logic [31:0]                in_vj,
  input  logic [31:0]                in_vk,
  input  logic                       in_pred_taken,
  input  logic [CDB_N-1:0]           cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]     cdb_tag,
  input  logic [CDB_N*32-1:0]        cdb_value,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output logic [31:0]                out_value,
  output logic                       out_taken,
  output logic [31:0]                out_target,
  output logic                       out_mispredict,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [9:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    tag_t        qj;
    tag_t        qk;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        pred;
  } slot_t;

  slot_t            slot_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  // older_q[a][b] set means slot a was inserted before slot b.
  logic [DEPTH-1:0] older_q [DEPTH];

  logic [32:0]      hit_j [DEPTH];
  logic [32:0]      hit_k [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             do_insert;
  slot_t            new_slot;
  logic [CNT_W-1:0] occ;

  logic             res_taken;
  logic [31:0]      res_target;
  logic [31:0]      res_value;
  logic             res_mispredict;

  // Returns {hit, value}; channels are scanned high to low so the lowest index wins.
  function automatic logic [32:0] snoop(input tag_t q,
                                        input logic [CDB_N-1:0] v,
                                        input logic [CDB_N*TAG_W-1:0] t,
                                        input logic [CDB_N*32-1:0] d);
    logic [32:0] r;
    r = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (v[c] && (q != '0) && (t[c*TAG_W +: TAG_W] == q)) r = {1'b1, d[c*32 +: 32]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit_j[i] = snoop(slot_q[i].qj, cdb_valid, cdb_tag, cdb_value);
      hit_k[i] = snoop(slot_q[i].qk, cdb_valid, cdb_tag, cdb_value);
      ready[i] = valid_q[i] && (slot_q[i].qj == '0) && (slot_q[i].qk == '0);
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + CNT_W'(valid_q[i]);
  end

  assign count     = occ;
  assign in_ready  = (occ != CNT_W'(DEPTH));
  assign do_insert = in_valid && in_ready && !clear_in;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // The oldest ready slot is the one no other ready slot is older than.
  always_comb begin : select_oldest
    logic blocked;
    blocked   = 1'b0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin : build_insert
    op_kind_e    kind;
    logic [32:0] byp_j;
    logic [32:0] byp_k;
    kind     = decode_op(in_op);
    new_slot = '{tag: in_tag, op: in_op, pc: in_pc, imm: in_imm,
                 qj: in_qj, qk: in_qk, vj: in_vj, vk: in_vk, pred: in_pred_taken};
    if (kind == K_JAL || kind == K_BAD) new_slot.qj = '0;
    if (kind == K_JAL || kind == K_BAD || kind == K_JALR) new_slot.qk = '0;
    byp_j = snoop(new_slot.qj, cdb_valid, cdb_tag, cdb_value);
    byp_k = snoop(new_slot.qk, cdb_valid, cdb_tag, cdb_value);
    if (byp_j[32]) begin
      new_slot.qj = '0;
      new_slot.vj = byp_j[31:0];
    end
    if (byp_k[32]) begin
      new_slot.qk = '0;
      new_slot.vk = byp_k[31:0];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (sel_found) valid_d[sel_idx] = 1'b0;
    if (do_insert) valid_d[free_idx] = 1'b1;
  end

  branch_resolve u_resolve (
    .op         (slot_q[sel_idx].op),
    .pc         (slot_q[sel_idx].pc),
    .imm        (slot_q[sel_idx].imm),
    .vj         (slot_q[sel_idx].vj),
    .vk         (slot_q[sel_idx].vk),
    .pred_taken (slot_q[sel_idx].pred),
    .taken      (res_taken),
    .target     (res_target),
    .value      (res_value),
    .mispredict (res_mispredict)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q        <= '0;
      out_valid      <= 1'b0;
      out_tag        <= '0;
      out_value      <= '0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_mispredict <= 1'b0;
    end else if (rdy_in) begin
      if (clear_in) begin
        valid_q   <= '0;
        out_valid <= 1'b0;
      end else begin
        valid_q   <= valid_d;
        out_valid <= sel_found;
        if (sel_found) begin
          out_tag        <= slot_q[sel_idx].tag;
          out_value      <= res_value;
          out_taken      <= res_taken;
          out_target     <= res_target;
          out_mispredict <= res_mispredict;
        end
      end
    end
  end

  // NOTE: slot payload and age matrix are not reset; valid_q alone decides
  // whether a slot's contents mean anything, and each insert rewrites them.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_insert && (free_idx == IDX_W'(i))) begin
          slot_q[i] <= new_slot;
        end else if (valid_q[i]) begin
          if (hit_j[i][32]) begin
            slot_q[i].qj <= '0;
            slot_q[i].vj <= hit_j[i][31:0];
          end
          if (hit_k[i][32]) begin
            slot_q[i].qk <= '0;
            slot_q[i].vk <= hit_k[i][31:0];
          end
        end
      end
      if (do_insert) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_q[free_idx][j] <= 1'b0;
          if (free_idx != IDX_W'(j)) older_q[j][free_idx] <= valid_q[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_station.sv
// Directed bench for branch_station with an in-order queue model of the
// station compared against the DUT every cycle.
module tb_branch_station;

  localparam int DEPTH = 8;
  localparam int TAG_W = 5;
  localparam int CDB_N = 3;

  localparam logic [9:0] JAL  = 10'h06F;
  localparam logic [9:0] JALR = 10'h067;
  localparam logic [9:0] BEQ  = 10'h063;
  localparam logic [9:0] BNE  = 10'h0E3;
  localparam logic [9:0] BLT  = 10'h263;
  localparam logic [9:0] BGE  = 10'h2E3;
  localparam logic [9:0] BLTU = 10'h363;
  localparam logic [9:0] BGEU = 10'h3E3;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   rdy_in;
  logic                   clear_in;
  logic                   in_valid;
  logic                   in_ready;
  logic [TAG_W-1:0]       in_tag;
  logic [9:0]             in_op;
  logic [31:0]            in_pc;
  logic [31:0]            in_imm;
  logic [TAG_W-1:0]       in_qj;
  logic [TAG_W-1:0]       in_qk;
  logic [31:0]            in_vj;
  logic [31:0]            in_vk;
  logic                   in_pred_taken;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*32-1:0]    cdb_value;
  logic                   out_valid;
  logic [TAG_W-1:0]       out_tag;
  logic [31:0]            out_value;
  logic                   out_taken;
  logic [31:0]            out_target;
  logic                   out_mispredict;
  logic [3:0]             count;

  int vectors = 0;
  int miscompares = 0;

  branch_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_N(CDB_N)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_qj(in_qj), .in_qk(in_qk),
    .in_vj(in_vj), .in_vk(in_vk), .in_pred_taken(in_pred_taken),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value),
    .out_taken(out_taken), .out_target(out_target),
    .out_mispredict(out_mispredict), .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: queue in insertion order ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [9:0]       op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vj;
    logic [31:0]      vk;
    bit               pred;
  } ent_t;

  ent_t             mq[$];
  bit               m_valid = 1'b0;
  logic [TAG_W-1:0] m_tag = '0;
  logic [31:0]      m_value = '0;
  logic [31:0]      m_target = '0;
  bit               m_taken = 1'b0;
  bit               m_mp = 1'b0;

  function automatic bit msnoop(input logic [TAG_W-1:0] q, output logic [31:0] v);
    v = '0;
    if (q == 0) return 1'b0;
    for (int c = 0; c < CDB_N; c++) begin
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == q) begin
        v = cdb_value[c*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void model_resolve(input ent_t e, output bit tk, output logic [31:0] tgt,
                                        output logic [31:0] val, output bit mp);
    bit is_b;
    bit c;
    is_b = 1'b1;
    c    = 1'b0;
    case (e.op)
      BEQ:     c = (e.vj == e.vk);
      BNE:     c = (e.vj != e.vk);
      BLT:     c = ($signed(e.vj) < $signed(e.vk));
      BGE:     c = !($signed(e.vj) < $signed(e.vk));
      BLTU:    c = (e.vj < e.vk);
      BGEU:    c = !(e.vj < e.vk);
      default: is_b = 1'b0;
    endcase
    if (is_b) begin
      tk = c; tgt = c ? e.pc + e.imm : e.pc + 32'd4; val = 32'd0; mp = (c != e.pred);
    end else if (e.op == JAL) begin
      tk = 1'b1; tgt = e.pc + e.imm; val = e.pc + 32'd4; mp = !e.pred;
    end else if (e.op == JALR) begin
      tk = 1'b1; tgt = (e.vj + e.imm) & 32'hFFFF_FFFE; val = e.pc + 32'd4; mp = 1'b1;
    end else begin
      tk = 1'b0; tgt = e.pc + 32'd4; val = e.pc + 32'd4; mp = e.pred;
    end
  endfunction

  always @(posedge clk_in) begin : model
    int          pick;
    int          pre;
    ent_t        e;
    logic [31:0] v;
    if (rst_in) begin
      mq.delete();
      m_valid = 1'b0;
    end else if (rdy_in) begin
      if (clear_in) begin
        mq.delete();
        m_valid = 1'b0;
      end else begin
        pre  = mq.size();
        pick = -1;
        for (int i = 0; i < mq.size(); i++)
          if (pick < 0 && mq[i].qj == 0 && mq[i].qk == 0) pick = i;
        m_valid = (pick >= 0);
        if (pick >= 0) begin
          model_resolve(mq[pick], m_taken, m_target, m_value, m_mp);
          m_tag = mq[pick].tag;
          mq.delete(pick);
        end
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          if (msnoop(e.qj, v)) begin e.qj = 0; e.vj = v; end
          if (msnoop(e.qk, v)) begin e.qk = 0; e.vk = v; end
          mq[i] = e;
        end
        if (in_valid && pre < DEPTH) begin
          e = '{tag: in_tag, op: in_op, pc: in_pc, imm: in_imm, qj: in_qj, qk: in_qk,
                vj: in_vj, vk: in_vk, pred: in_pred_taken};
          if (!(in_op inside {JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU})) e.qj = 0;
          if (!(in_op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU})) e.qk = 0;
          if (msnoop(e.qj, v)) begin e.qj = 0; e.vj = v; end
          if (msnoop(e.qk, v)) begin e.qk = 0; e.vk = v; end
          mq.push_back(e);
        end
      end
    end
  end

  always @(posedge clk_in) begin : compare
    #2;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("count", 32'(count), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (m_valid) begin
      check("out_tag", 32'(out_tag), 32'(m_tag));
      check("out_value", out_value, m_value);
      check("out_taken", 32'(out_taken), 32'(m_taken));
      check("out_target", out_target, m_target);
      check("out_mispredict", 32'(out_mispredict), 32'(m_mp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
    in_valid  = 1'b0;
    cdb_valid = '0;
    clear_in  = 1'b0;
  endtask

  task automatic ins(input logic [TAG_W-1:0] tag, input logic [9:0] op, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                     input logic [31:0] vj, input logic [31:0] vk, input bit pred);
    in_valid = 1'b1; in_tag = tag; in_op = op; in_pc = pc; in_imm = imm;
    in_qj = qj; in_qk = qk; in_vj = vj; in_vk = vk; in_pred_taken = pred;
  endtask

  task automatic bcast(input int ch, input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid[ch]              = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = tag;
    cdb_value[ch*32 +: 32]     = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; in_valid = 1'b0;
    in_tag = '0; in_op = '0; in_pc = '0; in_imm = '0; in_qj = '0; in_qk = '0;
    in_vj = '0; in_vk = '0; in_pred_taken = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    #3;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset count", 32'(count), 0);
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_target", out_target, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // BEQ equal operands, predicted not taken
    ins(1, BEQ, 32'h100, 32'h20, 0, 0, 5, 5, 0); step();
    check("beq count", 32'(count), 1);
    check("beq early valid", 32'(out_valid), 0);
    step();
    check("beq valid", 32'(out_valid), 1);
    check("beq taken", 32'(out_taken), 1);
    check("beq target", out_target, 32'h120);
    check("beq mispredict", 32'(out_mispredict), 1);
    check("beq value", out_value, 0);

    // signed vs unsigned compare; second insert overlaps first resolve
    ins(2, BLT, 32'h200, 32'h40, 0, 0, 32'hFFFF_FFFF, 1, 0); step();
    ins(3, BLTU, 32'h300, 32'h40, 0, 0, 32'hFFFF_FFFF, 1, 0); step();
    check("blt tag", 32'(out_tag), 2);
    check("blt taken", 32'(out_taken), 1);
    check("blt target", out_target, 32'h240);
    check("ins+res count", 32'(count), 1);
    step();
    check("bltu tag", 32'(out_tag), 3);
    check("bltu taken", 32'(out_taken), 0);
    check("bltu target", out_target, 32'h304);
    check("bltu mispredict", 32'(out_mispredict), 0);

    // JALR waits on qj (qk forced clear), woken via channel 1
    ins(3, JALR, 32'h400, 4, 7, 5, 0, 0, 1); step();
    bcast(1, 7, 32'h1003); step();
    check("jalr not yet", 32'(out_valid), 0);
    step();
    check("jalr valid", 32'(out_valid), 1);
    check("jalr target", out_target, 32'h1006);
    check("jalr value", out_value, 32'h404);
    check("jalr mispredict", 32'(out_mispredict), 1);

    // bypass at insert
    ins(4, BNE, 32'h500, 32'h10, 4, 0, 0, 9, 1); bcast(0, 4, 9); step(); step();
    check("bypass valid", 32'(out_valid), 1);
    check("bypass tag", 32'(out_tag), 4);
    check("bypass taken", 32'(out_taken), 0);
    check("bypass target", out_target, 32'h504);

    // JAL ignores its q fields
    ins(5, JAL, 32'h600, 32'h100, 13, 14, 0, 0, 1); step(); step();
    check("jal target", out_target, 32'h700);
    check("jal value", out_value, 32'h604);
    check("jal mispredict", 32'(out_mispredict), 0);

    // unknown op
    ins(6, 10'h3FF, 32'h700, 32'h40, 3, 3, 0, 0, 1); step(); step();
    check("badop valid", 32'(out_valid), 1);
    check("badop taken", 32'(out_taken), 0);
    check("badop target", out_target, 32'h704);
    check("badop mispredict", 32'(out_mispredict), 1);

    // same tag on two channels: lowest channel wins
    ins(7, JALR, 32'h800, 0, 9, 0, 0, 0, 0); step();
    bcast(0, 9, 32'h2000); bcast(2, 9, 32'h3000); step(); step();
    check("cdb priority target", out_target, 32'h2000);

    // qk wake-up, signed BGE against most negative value
    ins(8, BGE, 32'h900, 8, 0, 11, 5, 0, 0); step();
    bcast(2, 11, 32'h8000_0000); step(); step();
    check("bge taken", 32'(out_taken), 1);
    check("bge target", out_target, 32'h908);

    // fill, drop extra insert, then age order between slots 0 and 2
    for (int i = 0; i < DEPTH; i++) begin
      ins(TAG_W'(8 + i), BEQ, 32'hA00 + 32'(4 * i), 32'h10, TAG_W'(20 + i), 0, 0, 0, 0);
      step();
    end
    check("full count", 32'(count), DEPTH);
    check("full in_ready", 32'(in_ready), 0);
    ins(16, BEQ, 32'hB00, 0, 0, 0, 0, 0, 0); step();
    check("dropped count", 32'(count), DEPTH);
    check("dropped valid", 32'(out_valid), 0);
    bcast(0, 22, 0); bcast(1, 20, 0); step(); step();
    check("oldest first tag", 32'(out_tag), 8);
    check("oldest first count", 32'(count), 7);
    step();
    check("second tag", 32'(out_tag), 10);
    bcast(0, 21, 0); bcast(1, 23, 0); bcast(2, 24, 0); step();
    bcast(0, 25, 0); bcast(1, 26, 0); bcast(2, 27, 0); step();
    repeat (8) step();
    check("drained count", 32'(count), 0);

    // flush with a concurrent insert and a ready entry
    ins(20, BEQ, 32'hC00, 0, 28, 0, 0, 0, 0); step();
    ins(21, BEQ, 32'hC04, 0, 29, 0, 0, 0, 0); step();
    ins(22, BEQ, 32'hC08, 0, 0, 0, 0, 0, 0); step();
    check("pre-flush count", 32'(count), 3);
    clear_in = 1'b1;
    ins(23, BEQ, 32'hC0C, 0, 0, 0, 0, 0, 0); step();
    check("flush count", 32'(count), 0);
    check("flush valid", 32'(out_valid), 0);
    step();
    check("flush discarded insert", 32'(out_valid), 0);

    // rdy_in low freezes everything
    ins(24, BEQ, 32'hD00, 0, 30, 0, 0, 0, 0); step();
    ins(25, BNE, 32'hD04, 8, 0, 0, 1, 2, 1); step(); step();
    check("pre-stall tag", 32'(out_tag), 25);
    check("pre-stall target", out_target, 32'hD0C);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bcast(0, 30, 7);
      ins(26, BEQ, 32'hD10, 0, 0, 0, 0, 0, 0);
      step();
      check("stall valid", 32'(out_valid), 1);
      check("stall count", 32'(count), 1);
    end
    rdy_in = 1'b1;
    step();
    check("post-stall valid", 32'(out_valid), 0);
    check("post-stall count", 32'(count), 1);
    bcast(0, 30, 0); step(); step();
    check("post-stall wake tag", 32'(out_tag), 24);
    check("post-stall wake target", out_target, 32'hD00);

    // asynchronous reset mid-operation
    ins(27, BEQ, 32'hE00, 0, 31, 0, 0, 0, 0); step();
    ins(28, BEQ, 32'hE10, 4, 0, 0, 0, 0, 0); step(); step();
    check("pre-reset valid", 32'(out_valid), 1);
    #3 rst_in = 1'b1;
    #1;
    check("async reset valid", 32'(out_valid), 0);
    check("async reset count", 32'(count), 0);
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    ins(29, JAL, 32'h0, 32'h8, 0, 0, 0, 0, 1); step(); step();
    check("after reset target", out_target, 32'h8);
    check("after reset value", out_value, 32'h4);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
